video_frame_sync_ctrl: RTL and testbench

Sequencing controller for the camera-to-LCD line FIFO path. It watches camera vsync and the FIFO read-side fill level, and owns the FIFO reset and the timing-generator reset. It starts LCD timing only once a new camera frame has prefilled the FIFO. It gates FIFO reads with timing-generator DE, detects read underflow, and resynchronises automatically on underflow.

---
 rtl/video_frame_sync_ctrl.sv | 158 +++++++++++++++
 tb/tb_video_frame_sync_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_sync_ctrl.sv
// Camera-to-LCD frame sequencing: owns FIFO and timing-generator resets, releases
// LCD timing once a fresh camera frame has prefilled the line FIFO, resyncs on underflow.
module video_frame_sync_ctrl #(
    parameter int unsigned RNUM_WIDTH         = 11,
    parameter int unsigned PREFILL_WORDS      = 512,
    parameter int unsigned FIFO_RST_CYCLES    = 8,
    parameter int unsigned PREFILL_TIMEOUT    = 20'hFFFFF,
    parameter bit          RESYNC_EVERY_FRAME = 1'b0
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cam_vs,
    input  logic [RNUM_WIDTH-1:0] fifo_rnum,
    input  logic                  fifo_empty,
    input  logic                  tg_de,
    input  logic                  tg_vs,
    output logic                  fifo_rst,
    output logic                  tg_rst,
    output logic                  fifo_rd_en,
    output logic                  locked,
    output logic [7:0]            underflow_cnt,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_FLUSH,
        ST_PREFILL,
        ST_RUN
    } state_e;

    localparam logic [31:0] FLUSH_LAST   = 32'(FIFO_RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(PREFILL_TIMEOUT - 1);
    // One extra bit so a threshold of 2**RNUM_WIDTH is representable (never met).
    localparam logic [RNUM_WIDTH:0] PREFILL_THR = (RNUM_WIDTH + 1)'(PREFILL_WORDS);

    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [2:0]    vs_sync_q;
    logic          tg_vs_q;
    logic          fifo_rst_q, fifo_rst_d;
    logic          tg_rst_q, tg_rst_d;
    logic          locked_q, locked_d;
    logic [7:0]    ucnt_q, ucnt_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic vs_rise;
    logic tg_vs_rise;
    logic in_run;
    logic underflow;
    logic prefill_ok;

    assign vs_rise    = vs_sync_q[1] & ~vs_sync_q[2];
    assign tg_vs_rise = tg_vs & ~tg_vs_q;
    assign in_run     = (state_q == ST_RUN);
    assign underflow  = in_run & tg_de & fifo_empty;
    assign prefill_ok = ({1'b0, fifo_rnum} >= PREFILL_THR);

    // State, counters and registered outputs
    always_ff @(posedge video_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vs_sync_q  <= '0;
            tg_vs_q    <= 1'b0;
            fifo_rst_q <= 1'b1;
            tg_rst_q   <= 1'b1;
            locked_q   <= 1'b0;
            ucnt_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vs_sync_q  <= {vs_sync_q[1:0], cam_vs};
            tg_vs_q    <= tg_vs;
            fifo_rst_q <= fifo_rst_d;
            tg_rst_q   <= tg_rst_d;
            locked_q   <= locked_d;
            ucnt_q     <= ucnt_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Next-state logic; enable low overrides every per-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (vs_rise) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) state_d = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (prefill_ok)                  state_d = ST_RUN;
                else if (cnt_q == TIMEOUT_LAST)  state_d = ST_WAIT_VS;
            end
            ST_RUN: begin
                if (underflow)                            state_d = ST_WAIT_VS;
                else if (RESYNC_EVERY_FRAME && vs_rise)   state_d = ST_FLUSH;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) state_d = ST_IDLE;
    end

    // Cycle counter restarts on every state change and only runs in timed states
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == ST_FLUSH) || (state_q == ST_PREFILL)))
            cnt_d = cnt_q + 32'd1;
    end

    // Event counters: a coincident underflow suppresses the frame count
    always_comb begin
        ucnt_d = ucnt_q;
        fcnt_d = fcnt_q;
        if (underflow && (ucnt_q != 8'hFF))
            ucnt_d = ucnt_q + 8'd1;
        if (in_run && tg_vs_rise && !underflow)
            fcnt_d = fcnt_q + 16'd1;
    end

    // Output decode from next state so outputs move on the same edge as the state
    always_comb begin
        fifo_rst_d = 1'b1;
        tg_rst_d   = 1'b1;
        locked_d   = 1'b0;
        case (state_d)
            ST_PREFILL: begin
                fifo_rst_d = 1'b0;
            end
            ST_RUN: begin
                fifo_rst_d = 1'b0;
                tg_rst_d   = 1'b0;
                locked_d   = 1'b1;
            end
            default: begin
                fifo_rst_d = 1'b1;
                tg_rst_d   = 1'b1;
                locked_d   = 1'b0;
            end
        endcase
    end

    assign fifo_rst      = fifo_rst_q;
    assign tg_rst        = tg_rst_q;
    assign locked        = locked_q;
    assign underflow_cnt = ucnt_q;
    assign frame_cnt     = fcnt_q;
    assign fifo_rd_en    = tg_de & in_run & ~fifo_empty;

endmodule

// File: tb/tb_video_frame_sync_ctrl.sv
// Self-checking bench for video_frame_sync_ctrl: three instances (default, short
// prefill timeout, resync-every-frame) share one stimulus stream.
module tb_video_frame_sync_ctrl;

    logic        video_clk = 1'b0;
    logic        rst, enable, cam_vs, fifo_empty, tg_de, tg_vs;
    logic [10:0] fifo_rnum;

    logic        m_fifo_rst, m_tg_rst, m_rd_en, m_locked;
    logic [7:0]  m_ucnt;
    logic [15:0] m_fcnt;
    logic        t_fifo_rst, t_tg_rst, t_rd_en, t_locked;
    logic [7:0]  t_ucnt;
    logic [15:0] t_fcnt;
    logic        r_fifo_rst, r_tg_rst, r_rd_en, r_locked;
    logic [7:0]  r_ucnt;
    logic [15:0] r_fcnt;

    always #5 video_clk = ~video_clk;

    video_frame_sync_ctrl u_main (
        .video_clk(video_clk), .rst(rst), .enable(enable), .cam_vs(cam_vs),
        .fifo_rnum(fifo_rnum), .fifo_empty(fifo_empty), .tg_de(tg_de), .tg_vs(tg_vs),
        .fifo_rst(m_fifo_rst), .tg_rst(m_tg_rst), .fifo_rd_en(m_rd_en), .locked(m_locked),
        .underflow_cnt(m_ucnt), .frame_cnt(m_fcnt)
    );

    video_frame_sync_ctrl #(.PREFILL_TIMEOUT(100)) u_to (
        .video_clk(video_clk), .rst(rst), .enable(enable), .cam_vs(cam_vs),
        .fifo_rnum(fifo_rnum), .fifo_empty(fifo_empty), .tg_de(tg_de), .tg_vs(tg_vs),
        .fifo_rst(t_fifo_rst), .tg_rst(t_tg_rst), .fifo_rd_en(t_rd_en), .locked(t_locked),
        .underflow_cnt(t_ucnt), .frame_cnt(t_fcnt)
    );

    video_frame_sync_ctrl #(.RESYNC_EVERY_FRAME(1'b1)) u_rs (
        .video_clk(video_clk), .rst(rst), .enable(enable), .cam_vs(cam_vs),
        .fifo_rnum(fifo_rnum), .fifo_empty(fifo_empty), .tg_de(tg_de), .tg_vs(tg_vs),
        .fifo_rst(r_fifo_rst), .tg_rst(r_tg_rst), .fifo_rd_en(r_rd_en), .locked(r_locked),
        .underflow_cnt(r_ucnt), .frame_cnt(r_fcnt)
    );

    int checks = 0;
    int errors = 0;
    int rd_while_empty = 0;

    typedef struct {
        logic        en, cam;
        logic [10:0] rnum;
        logic        empty, de, vs;
        logic [3:0]  exp;   // {fifo_rst, tg_rst, locked, fifo_rd_en}
        string       note;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       note;
    } sb_t;

    vec_t tbl[12];
    sb_t  sbq[$];

    // Reads must never coincide with an empty FIFO, on any instance
    always @(negedge video_clk)
        if ((m_rd_en || t_rd_en || r_rd_en) && fifo_empty) rd_while_empty++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge video_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic cam, input logic [10:0] rnum,
                                input logic empty, input logic de, input logic vs,
                                input logic [3:0] exp, input string note);
        vec_t v;
        v.en = en; v.cam = cam; v.rnum = rnum; v.empty = empty; v.de = de; v.vs = vs;
        v.exp = exp; v.note = note;
        return v;
    endfunction

    // Camera vsync pulse followed by a bounded wait for u_main to lock
    task automatic relock(output bit ok);
        ok = 1'b0;
        cam_vs = 1'b1;
        cyc();
        cam_vs = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (m_locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int m_lock_at, m_tg_at, r_lock_at, t_to_at, t_tg_low;
        int relocks, rs_flush, stayed;
        sb_t e;

        // IDLE->WAIT_VS, vsync through synchroniser, 8-cycle flush, PREFILL entry
        tbl[0]  = mk(1, 0, 0, 1, 1, 0, 4'b1100, "idle_to_wait");
        tbl[1]  = mk(1, 1, 0, 0, 1, 0, 4'b1100, "cam_sampled");
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 4'b1100, "sync_stage2");
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 4'b1100, "flush_entry");
        for (int i = 4; i <= 10; i++)
            tbl[i] = mk(1, 0, 0, 0, 0, 0, 4'b1100, "flush_hold");
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 4'b0100, "prefill_entry");

        rst = 1'b1; enable = 1'b0; cam_vs = 1'b0; fifo_rnum = '0;
        fifo_empty = 1'b0; tg_de = 1'b1; tg_vs = 1'b0;
        cyc();
        cyc();
        chk("rst_fifo_rst", 32'(m_fifo_rst), 32'd1);
        chk("rst_tg_rst",   32'(m_tg_rst),   32'd1);
        chk("rst_locked",   32'(m_locked),   32'd0);
        chk("rst_rd_en",    32'(m_rd_en),    32'd0);
        chk("rst_ucnt",     32'(m_ucnt),     32'd0);
        chk("rst_fcnt",     32'(m_fcnt),     32'd0);

        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            enable = tbl[i].en; cam_vs = tbl[i].cam; fifo_rnum = tbl[i].rnum;
            fifo_empty = tbl[i].empty; tg_de = tbl[i].de; tg_vs = tbl[i].vs;
            sbq.push_back('{32'(tbl[i].exp), tbl[i].note});
            cyc();
            e = sbq.pop_front();
            chk(e.note, 32'({m_fifo_rst, m_tg_rst, m_locked, m_rd_en}), e.exp);
            chk({"rs_", e.note}, 32'({r_fifo_rst, r_tg_rst, r_locked, r_rd_en}), e.exp);
        end

        // Prefill ramp: lock at the edge where rnum reaches 512; u_to gives up after 100
        m_lock_at = -1; m_tg_at = -1; r_lock_at = -1; t_to_at = -1; t_tg_low = 0;
        for (int i = 1; i <= 600; i++) begin
            fifo_rnum = 11'(i);
            cyc();
            if (m_locked && m_lock_at < 0)  m_lock_at = i;
            if (!m_tg_rst && m_tg_at < 0)   m_tg_at = i;
            if (r_locked && r_lock_at < 0)  r_lock_at = i;
            if (t_fifo_rst && t_to_at < 0)  t_to_at = i;
            if (!t_tg_rst)                  t_tg_low++;
        end
        chk("prefill_lock_edge",   32'(m_lock_at), 32'd512);
        chk("prefill_tg_rst_edge", 32'(m_tg_at),   32'd512);
        chk("rs_prefill_lock",     32'(r_lock_at), 32'd512);
        chk("timeout_cycles",      32'(t_to_at),   32'd100);
        chk("timeout_tg_rst_held", 32'(t_tg_low),  32'd0);

        // Frame counting in RUN, reads follow tg_de
        fifo_empty = 1'b0; tg_de = 1'b1;
        #1;
        chk("rd_en_in_run", 32'(m_rd_en), 32'd1);
        for (int p = 1; p <= 3; p++) begin
            tg_vs = 1'b1;
            sbq.push_back('{32'(p), "frame_cnt_pulse"});
            cyc();
            e = sbq.pop_front();
            chk(e.note, 32'(m_fcnt), e.exp);
            tg_vs = 1'b0;
            cyc();
        end
        chk("timeout_inst_fcnt", 32'(t_fcnt), 32'd0);

        // Fourth pulse collides with an underflow: underflow wins
        tg_vs = 1'b1; fifo_empty = 1'b1;
        #1;
        chk("rd_en_blocked_empty", 32'(m_rd_en), 32'd0);
        cyc();
        chk("uf_ucnt",      32'(m_ucnt),   32'd1);
        chk("uf_fcnt_held", 32'(m_fcnt),   32'd3);
        chk("uf_locked",    32'(m_locked), 32'd0);
        chk("uf_tg_rst",    32'(m_tg_rst), 32'd1);
        fifo_empty = 1'b0;
        #1;
        chk("uf_rd_en_dropped", 32'(m_rd_en), 32'd0);
        tg_vs = 1'b0; tg_de = 1'b0;
        cyc();

        // Drive the underflow counter into saturation
        relocks = 0;
        for (int n = 0; n < 299; n++) begin
            relock(ok);
            if (ok) relocks++;
            tg_de = 1'b1; fifo_empty = 1'b1;
            cyc();
            tg_de = 1'b0; fifo_empty = 1'b0;
            if (n == 0) chk("uf_second", 32'(m_ucnt), 32'd2);
        end
        chk("relock_count", 32'(relocks), 32'd299);
        chk("ucnt_sat_main", 32'(m_ucnt), 32'd255);
        chk("ucnt_sat_to",   32'(t_ucnt), 32'd255);
        chk("ucnt_sat_rs",   32'(r_ucnt), 32'd255);

        // Camera vsync while running: only the resync instance flushes
        relock(ok);
        chk("resync_lock", 32'(ok), 32'd1);
        cam_vs = 1'b1;
        cyc();
        cam_vs = 1'b0;
        cyc();
        chk("resync_not_yet", 32'(r_locked), 32'd1);
        cyc();
        chk("resync_flush_rst",  32'(r_fifo_rst), 32'd1);
        chk("resync_unlocked",   32'(r_locked),   32'd0);
        chk("noresync_locked",   32'(m_locked),   32'd1);
        chk("noresync_fifo_rst", 32'(m_fifo_rst), 32'd0);
        rs_flush = 1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (r_fifo_rst) rs_flush++;
            else break;
        end
        chk("resync_flush_len", 32'(rs_flush), 32'd8);
        cyc();
        chk("resync_relocked",   32'(r_locked), 32'd1);
        chk("noresync_held",     32'(m_locked), 32'd1);

        // enable drop while in PREFILL
        tg_de = 1'b1; fifo_empty = 1'b1;
        cyc();
        tg_de = 1'b0; fifo_empty = 1'b0; fifo_rnum = 11'd10;
        cam_vs = 1'b1;
        cyc();
        cam_vs = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (!m_fifo_rst) break;
        end
        chk("prefill_reached", 32'(m_fifo_rst), 32'd0);
        chk("prefill_tg_rst",  32'(m_tg_rst),   32'd1);
        enable = 1'b0;
        cyc();
        chk("dis_fifo_rst", 32'(m_fifo_rst), 32'd1);
        chk("dis_tg_rst",   32'(m_tg_rst),   32'd1);
        chk("dis_locked",   32'(m_locked),   32'd0);
        enable = 1'b1;
        stayed = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (m_fifo_rst) stayed++;
        end
        chk("idle_waits_for_vs", 32'(stayed), 32'd20);

        // Synchronous reset in RUN clears counters on the same edge
        fifo_rnum = 11'd600;
        relock(ok);
        chk("pre_rst_lock", 32'(ok),     32'd1);
        chk("pre_rst_fcnt", 32'(m_fcnt), 32'd3);
        tg_de = 1'b1;
        rst = 1'b1;
        cyc();
        chk("midrst_locked",   32'(m_locked),   32'd0);
        chk("midrst_tg_rst",   32'(m_tg_rst),   32'd1);
        chk("midrst_fifo_rst", 32'(m_fifo_rst), 32'd1);
        chk("midrst_rd_en",    32'(m_rd_en),    32'd0);
        chk("midrst_ucnt",     32'(m_ucnt),     32'd0);
        chk("midrst_fcnt",     32'(m_fcnt),     32'd0);
        rst = 1'b0; tg_de = 1'b0;
        cyc();

        chk("rd_while_empty", 32'(rd_while_empty), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
